timing_peak_det: RTL
====================

// Module: timing_peak_det
// PURPOSE
//  Downstream of the sliding-window P-metric accumulator in the 802.16 timing-sync chain.
//  Takes the running correlation P (complex, 7.FBIT2) and the window energy R.
//  Compares |P|^2 against a programmable fraction of R^2 and tracks the maximum over the plateau.
//  Emits one strobe with the index and value of the peak sample: the coarse symbol start.
// PARAMETERS
//  FBIT2    7    fractional bits of P/R; P, R are WP=7+FBIT2 bits
//  THR_NUM  128  threshold numerator (unsigned 8b); threshold = THR_NUM/2^THR_SH
//  THR_SH   8    threshold shift
//  HOLD     4    consecutive below-threshold samples that close a plateau (>=1)
//  WIN      64   max samples tracked per plateau before forced report (>=2)
//  LOCKOUT  256  samples ignored after a report (>=1)
//  CW       16   sample-index counter width
// PORTS
//  clk      in   1      clock, all flops posedge
//  rst      in   1      asynchronous, active-low reset
//  ena      in   1      sample strobe, same qualifier as the accumulator's ena
//  srch_en  in   1      1 = search armed; 0 forces SEARCH, suppresses detection
//  p_re     in   WP     signed Re{P}, 7.FBIT2
//  p_im     in   WP     signed Im{P}, 7.FBIT2
//  r_en     in   WP     signed window energy R (>=0 in use), 7.FBIT2
//  det_valid out 1      one-clk pulse: peak found
//  det_idx  out  CW     index of peak input sample (accepted-ena count since reset, wraps mod 2^CW)
//  det_pk   out  2*WP   |P|^2 of peak sample, unsigned
//  busy     out  1      FSM not in SEARCH
// BEHAVIOUR
//  Reset (rst=0, async): all outputs 0, FSM=SEARCH, pipeline valid flags and counters cleared.
//  Applies at any time, incl. mid-plateau; a pending report is discarded.
//  Pipeline, advances only on ena=1:
//   S1 registers p_re^2, p_im^2, r_en^2 (signed multiply).
//   S2 mag2 = sum (2*WP bits unsigned), rhs = THR_NUM*r2 (2*WP+8).
//   S3 above = ({mag2,THR_SH'b0} >= rhs), unsigned compare, no truncation.
//  FSM consumes sample n on the ena edge that accepts input n+3.
//  Samples 0..2 after reset are pipeline fill; the FSM ignores them via valid flags.
//  FSM, all transitions on ena=1 except REPORT:
//   SEARCH: above -> TRACK; pk<=mag2, pk_idx<=n, win=1, blw=0.
//   TRACK:  mag2>pk (strict; ties keep earlier) -> update pk/pk_idx.
//           blw <= above ? 0 : blw+1. win++.
//           (blw reaches HOLD) or (win==WIN) -> REPORT.
//   REPORT: exactly one clk regardless of ena. det_valid=1; det_idx/det_pk load pk_idx/pk.
//           Outputs hold until the next report. -> LOCK, lck=0.
//           An ena sample in this clk counts as lockout sample 1.
//   LOCK:   lck++ per sample; lck==LOCKOUT -> SEARCH. above ignored.
//  srch_en=0: FSM -> SEARCH next clk from any state except REPORT (REPORT completes).
//   Pipeline and index counter keep running.
//  Index counter wraps silently. det_idx is the raw wrapped value.
//  ena=0 gaps: state, pipeline and counters freeze. Results identical to continuous ena.
// STRUCTURE
//  Package ofdm_sync_pkg: state enum {SEARCH,TRACK,REPORT,LOCK}; WP/metric width constants.
//  Sub-module timing_metric_pipe: S1-S3 arithmetic, outputs mag2/above/valid.
//  Parent holds FSM, counters, output registers.
// TESTING (FBIT2=7, THR 128/2^8=0.5, HOLD=4, WIN=64, LOCKOUT=256; R=128 const)
//  Reset mid-TRACK, release -> all outputs 0, busy=0, no det_valid until a new plateau.
//  P_re=64 all samples -> mag2=4096 below threshold; det_valid never asserted.
//  P_re=128 on samples 10..19, 160 at 14, else 0 -> single det_valid, det_idx=14, det_pk=25600.
//   Pulse the clk after sample 23 is consumed (input 26 accepted, continuous ena).
//  P_re=128 for 100 samples from 5 -> report at win=64, det_idx=5, det_pk=16384.
//   No second report within LOCKOUT.
//  Equal peaks 150 at samples 12 and 15 -> det_idx=12.
//  Random ena gaps (~50% duty) on the plateau case -> same det_idx/det_pk.
//  srch_en dropped at sample 16 -> no pulse.

Source files
------------

// File: rtl/ofdm_sync_pkg.sv
// Shared types for the OFDM timing-sync chain: peak-detector states and metric widths.
// No logic; latency and backpressure not applicable.
package ofdm_sync_pkg;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    TRACK  = 2'd1,
    REPORT = 2'd2,
    LOCK   = 2'd3
  } state_t;

  localparam int FBIT2_DEF = 7;
  localparam int WP_DEF    = 7 + FBIT2_DEF;
  localparam int MW_DEF    = 2 * WP_DEF;

  // P and R carry 7 integer bits ahead of the fractional field.
  function automatic int wp_of(input int fbit2);
    return 7 + fbit2;
  endfunction

endpackage

// File: rtl/timing_metric_pipe.sv
// Squares P and R, forms |P|^2 and THR_NUM*R^2, flags |P|^2 >= thr*R^2.
// Latency 3 accepted samples; no backpressure, every stage stalls while ena=0.
module timing_metric_pipe
  import ofdm_sync_pkg::*;
#(
  parameter int FBIT2   = 7,
  parameter int THR_NUM = 128,
  parameter int THR_SH  = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ena,
  input  logic signed [wp_of(FBIT2)-1:0] p_re,
  input  logic signed [wp_of(FBIT2)-1:0] p_im,
  input  logic signed [wp_of(FBIT2)-1:0] r_en,
  output logic [2*wp_of(FBIT2)-1:0]    mag2,
  output logic                         above,
  output logic                         valid
);

  localparam int WP  = wp_of(FBIT2);
  localparam int MW  = 2 * WP;
  localparam int RW  = MW + 8;
  localparam int CMW = RW + THR_SH;
  localparam logic [7:0] THR = 8'(THR_NUM);

  logic signed [MW-1:0] re_x, im_x, r_x;
  logic signed [MW-1:0] re2_s1, im2_s1, r2_s1;
  logic [MW-1:0]        mag2_s2;
  logic [RW-1:0]        rhs_s2;
  logic                 v_s1, v_s2;
  logic [CMW-1:0]       lhs_cmp, rhs_cmp;

  assign re_x = (MW)'(p_re);
  assign im_x = (MW)'(p_im);
  assign r_x  = (MW)'(r_en);

  // Both sides widened so the compare never drops a bit of either operand.
  assign lhs_cmp = (CMW)'(mag2_s2) << THR_SH;
  assign rhs_cmp = (CMW)'(rhs_s2);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      re2_s1  <= '0;
      im2_s1  <= '0;
      r2_s1   <= '0;
      mag2_s2 <= '0;
      rhs_s2  <= '0;
      mag2    <= '0;
      above   <= 1'b0;
      v_s1    <= 1'b0;
      v_s2    <= 1'b0;
      valid   <= 1'b0;
    end else if (ena) begin
      re2_s1  <= re_x * re_x;
      im2_s1  <= im_x * im_x;
      r2_s1   <= r_x * r_x;
      mag2_s2 <= $unsigned(re2_s1) + $unsigned(im2_s1);
      rhs_s2  <= (RW)'($unsigned(r2_s1)) * (RW)'(THR);
      mag2    <= mag2_s2;
      above   <= (lhs_cmp >= rhs_cmp);
      v_s1    <= 1'b1;
      v_s2    <= v_s1;
      valid   <= v_s2;
    end
  end

endmodule

// File: rtl/timing_peak_det.sv
// Plateau peak search on |P|^2 vs thr*R^2; one det_valid strobe per plateau with peak index/value.
// Report 3 samples + plateau close after the peak; no backpressure, ena gaps freeze everything.
module timing_peak_det
  import ofdm_sync_pkg::*;
#(
  parameter int FBIT2   = 7,
  parameter int THR_NUM = 128,
  parameter int THR_SH  = 8,
  parameter int HOLD    = 4,
  parameter int WIN     = 64,
  parameter int LOCKOUT = 256,
  parameter int CW      = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           ena,
  input  logic                           srch_en,
  input  logic signed [wp_of(FBIT2)-1:0] p_re,
  input  logic signed [wp_of(FBIT2)-1:0] p_im,
  input  logic signed [wp_of(FBIT2)-1:0] r_en,
  output logic                           det_valid,
  output logic [CW-1:0]                  det_idx,
  output logic [2*wp_of(FBIT2)-1:0]      det_pk,
  output logic                           busy
);

  localparam int WP  = wp_of(FBIT2);
  localparam int MW  = 2 * WP;
  localparam int BW  = $clog2(HOLD + 1);
  localparam int WW  = $clog2(WIN + 1);
  localparam int LW  = $clog2(LOCKOUT + 1);
  localparam logic [BW-1:0] HOLD_C = BW'(HOLD);
  localparam logic [WW-1:0] WIN_C  = WW'(WIN);
  localparam logic [LW-1:0] LCK_C  = LW'(LOCKOUT);

  logic [MW-1:0] mag2;
  logic          above, v3;

  timing_metric_pipe #(
    .FBIT2  (FBIT2),
    .THR_NUM(THR_NUM),
    .THR_SH (THR_SH)
  ) u_pipe (
    .clk  (clk),
    .rst  (rst),
    .ena  (ena),
    .p_re (p_re),
    .p_im (p_im),
    .r_en (r_en),
    .mag2 (mag2),
    .above(above),
    .valid(v3)
  );

  state_t        state, state_n;
  logic [CW-1:0] idx_cnt, pk_idx, pk_idx_n, cur_idx;
  logic [MW-1:0] pk, pk_n;
  logic [WW-1:0] win, win_n;
  logic [BW-1:0] blw, blw_n;
  logic [LW-1:0] lck, lck_n;
  logic          take, rep_go;

  // The sample leaving the pipeline entered three accepted inputs ago.
  assign cur_idx = idx_cnt - CW'(3);
  assign take    = ena & v3;
  assign busy    = (state != SEARCH);

  always_comb begin
    state_n  = state;
    pk_n     = pk;
    pk_idx_n = pk_idx;
    win_n    = win;
    blw_n    = blw;
    lck_n    = lck;
    rep_go   = 1'b0;
    case (state)
      SEARCH: begin
        if (take && srch_en && above) begin
          state_n  = TRACK;
          pk_n     = mag2;
          pk_idx_n = cur_idx;
          win_n    = WW'(1);
          blw_n    = '0;
        end
      end
      TRACK: begin
        if (!srch_en) begin
          state_n = SEARCH;
        end else if (take) begin
          if (mag2 > pk) begin
            pk_n     = mag2;
            pk_idx_n = cur_idx;
          end
          blw_n = above ? '0 : blw + BW'(1);
          win_n = win + WW'(1);
          if (blw_n == HOLD_C || win_n == WIN_C) begin
            state_n = REPORT;
            rep_go  = 1'b1;
          end
        end
      end
      REPORT: begin
        // A sample accepted during the report clock is the first lockout sample.
        lck_n   = ena ? LW'(1) : '0;
        state_n = (ena && lck_n == LCK_C) ? SEARCH : LOCK;
      end
      LOCK: begin
        if (!srch_en) begin
          state_n = SEARCH;
        end else if (take) begin
          lck_n = lck + LW'(1);
          if (lck_n == LCK_C) state_n = SEARCH;
        end
      end
      default: state_n = SEARCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= SEARCH;
      idx_cnt   <= '0;
      pk        <= '0;
      pk_idx    <= '0;
      win       <= '0;
      blw       <= '0;
      lck       <= '0;
      det_valid <= 1'b0;
      det_idx   <= '0;
      det_pk    <= '0;
    end else begin
      state     <= state_n;
      pk        <= pk_n;
      pk_idx    <= pk_idx_n;
      win       <= win_n;
      blw       <= blw_n;
      lck       <= lck_n;
      det_valid <= rep_go;
      if (ena) idx_cnt <= idx_cnt + CW'(1);
      if (rep_go) begin
        det_idx <= pk_idx_n;
        det_pk  <= pk_n;
      end
    end
  end

endmodule
